cycle_controller: RTL and testbench
===================================

CYCLE_CONTROLLER -- requirements
Module: cycle_controller

Interface
REQ-001 The block SHALL have parameter OPCODE_WIDTH, default 4: the width of the opcode field.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock, rising-edge active.
REQ-003 The block SHALL have port input_clear_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port input_clock_enable, input, 1 bit: when 1, the state may advance on the edge; when 0, all state holds.
REQ-005 The block SHALL have port input_opcode, input, OPCODE_WIDTH bits: the opcode field from the memory data bus, sampled at fetch completion.
REQ-006 The block SHALL have port input_mem_ack, input, 1 bit: memory acknowledge for the current fetch request.
REQ-007 The block SHALL have ports output_fetch, output_decode, output_execute and output_increment, each output, 1 bit: one-hot phase indicators.
REQ-008 The block SHALL have port output_mem_req, output, 1 bit: instruction fetch request.
REQ-009 The block SHALL have port output_ir_load, output, 1 bit: single-cycle instruction register load strobe.
REQ-010 The block SHALL have port output_exec_step, output, 2 bits: the execute micro-step index.
REQ-011 The block SHALL have ports output_pc_increment and output_pc_load, each output, 1 bit: program counter controls.
REQ-012 The block SHALL have port output_halted, output, 1 bit: the processor is stopped.

Function
REQ-013 The FSM SHALL have the states FETCH, DECODE, EXECUTE, INCREMENT and HALTED, and SHALL update only on rising clock edges where input_clock_enable=1.
REQ-014 FETCH SHALL drive output_fetch=1 and output_mem_req=1, and SHALL hold until input_mem_ack=1 on an enabled edge; on that edge it SHALL latch input_opcode, pulse output_ir_load for the following cycle, and go to DECODE.
REQ-015 DECODE SHALL last exactly one enabled cycle, SHALL look up the execute length L from the latched opcode, and SHALL go to HALTED if the opcode is HLT, otherwise to EXECUTE with step=0.
REQ-016 EXECUTE SHALL drive output_exec_step=step, SHALL increment step on each enabled edge, and SHALL go to INCREMENT when step equals L-1; step SHALL never exceed 2.
REQ-017 The execute length table SHALL be: NOP 0x0 = 1; LDA 0x1 = 3; ADD 0x2 = 3; SUB 0x3 = 3; STA 0x4 = 2; LDI 0x5 = 1; JMP 0x6 = 1; 0x7..0xE = 1.
REQ-018 For JMP, output_pc_load SHALL be 1 during EXECUTE step 0.
REQ-019 INCREMENT SHALL last one enabled cycle, SHALL assert output_pc_increment unless the opcode is JMP, and SHALL then go to FETCH.
REQ-020 HLT 0xF SHALL put the FSM in HALTED, where it SHALL stay with output_halted=1, all phase outputs 0 and output_mem_req=0, until reset.
REQ-021 When input_clock_enable=0, all outputs SHALL hold their values; output_ir_load SHALL NOT re-pulse.
REQ-022 input_mem_ack SHALL be ignored outside FETCH.
REQ-023 An acknowledge that arrives while input_clock_enable=0 SHALL be ignored, so the acknowledge must be seen on an enabled edge.
REQ-024 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.
REQ-025 Exactly one phase output SHALL be 1 in every non-HALTED state.

Reset
REQ-026 When input_clear_n=0, the block SHALL immediately force state=FETCH, step=0 and latched opcode=0x0, regardless of clock or enable.
REQ-027 The reset values SHALL be: output_fetch=1, output_mem_req=1, and all other outputs 0.
REQ-028 A reset mid-EXECUTE or mid-HALTED SHALL abandon the instruction without any PC pulse.
REQ-029 Release of reset SHALL be synchronous to clock, and FETCH SHALL start on the first enabled edge after release.

Structure
REQ-030 The package cycle_ctrl_pkg SHALL hold the state encoding, the opcode constants (NOP..HLT) and the phase-output bit positions.
REQ-031 The execute length table SHALL be a combinational sub-module exec_length_rom (opcode in, 2-bit length and is_halt/is_jump flags out).

Verification
REQ-032 The bench SHALL check reset: input_clear_n=0 mid-clock -> output_fetch=1, output_mem_req=1, all else 0, with no edge required.
REQ-033 The bench SHALL check NOP: opcode 0x0 with ack tied 1 and CE=1 -> fetch, decode, execute(step 0), increment(pc_increment=1), fetch, a 4-cycle loop.
REQ-034 The bench SHALL check LDA with wait: opcode 0x1 with ack delayed 2 cycles -> fetch for 3 cycles, ir_load for 1 cycle, exec_step 0,1,2, then increment, 8 cycles total.
REQ-035 The bench SHALL check JMP: opcode 0x6 -> pc_load=1 at step 0, and pc_increment=0 during INCREMENT.
REQ-036 The bench SHALL check clock enable: CE=0 for 3 cycles during ADD step 1 -> outputs frozen, then resume at step 2 on the first enabled edge.
REQ-037 The bench SHALL check halt and reset: opcode 0xF -> HALTED and output_halted=1 held for 10 cycles with ack ignored; a reset pulse then returns to FETCH.

Source files
------------

// File: rtl/cycle_ctrl_pkg.sv
// Shared encodings for the instruction cycle controller: FSM states,
// opcode values, phase-output bit positions and the execute-length record.
package cycle_ctrl_pkg;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_INCREMENT = 3'd3;
  localparam logic [2:0] ST_HALTED    = 3'd4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit positions inside the 4-bit one-hot phase vector.
  localparam int unsigned PH_FETCH     = 3;
  localparam int unsigned PH_DECODE    = 2;
  localparam int unsigned PH_EXECUTE   = 1;
  localparam int unsigned PH_INCREMENT = 0;

  typedef struct packed {
    logic [1:0] length;
    logic       is_halt;
    logic       is_jump;
  } exec_info_t;

endpackage

// File: rtl/cycle_controller_if.sv
// Opcode/acknowledge inputs and all controller outputs, bundled as one bus.
interface cycle_controller_if #(
  parameter int unsigned OPCODE_WIDTH = 4
);
  logic [OPCODE_WIDTH-1:0] input_opcode;
  logic                    input_mem_ack;
  logic                    output_fetch;
  logic                    output_decode;
  logic                    output_execute;
  logic                    output_increment;
  logic                    output_mem_req;
  logic                    output_ir_load;
  logic [1:0]              output_exec_step;
  logic                    output_pc_increment;
  logic                    output_pc_load;
  logic                    output_halted;

  modport master (
    output input_opcode, input_mem_ack,
    input  output_fetch, output_decode, output_execute, output_increment,
    input  output_mem_req, output_ir_load, output_exec_step,
    input  output_pc_increment, output_pc_load, output_halted
  );

  modport slave (
    input  input_opcode, input_mem_ack,
    output output_fetch, output_decode, output_execute, output_increment,
    output output_mem_req, output_ir_load, output_exec_step,
    output output_pc_increment, output_pc_load, output_halted
  );
endinterface

// File: rtl/exec_length_rom.sv
// Combinational opcode lookup: execute length plus halt/jump flags.
module exec_length_rom
  import cycle_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output exec_info_t              info
);

  // Table lookup; every undefined opcode executes in a single step.
  always_comb begin
    info = '{length: 2'd1, is_halt: 1'b0, is_jump: 1'b0};
    case (opcode)
      OPCODE_WIDTH'(OP_LDA),
      OPCODE_WIDTH'(OP_ADD),
      OPCODE_WIDTH'(OP_SUB): info.length = 2'd3;
      OPCODE_WIDTH'(OP_STA): info.length = 2'd2;
      OPCODE_WIDTH'(OP_JMP): info.is_jump = 1'b1;
      OPCODE_WIDTH'(OP_HLT): info.is_halt = 1'b1;
      default:               info.length = 2'd1;
    endcase
  end

endmodule

// File: rtl/cycle_controller.sv
// Fetch/decode/execute/increment sequencer with clock enable and halt.
// All outputs are decoded from registered state only.
module cycle_controller
  import cycle_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  logic               clock,
  input  logic               input_clear_n,
  input  logic               input_clock_enable,
  cycle_controller_if.slave  bus
);

  logic [2:0]              state;
  logic [1:0]              step;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  exec_info_t              info;
  logic [3:0]              phase;
  logic                    last_step;

  exec_length_rom #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_rom (
    .opcode (opcode_q),
    .info   (info)
  );

  // The step==2 term caps the counter even if the table ever yields length 0.
  assign last_step = (step == info.length - 2'd1) || (step == 2'd2);

  // State, micro-step and latched opcode; everything holds while enable is low.
  always_ff @(posedge clock or negedge input_clear_n) begin
    if (!input_clear_n) begin
      state    <= ST_FETCH;
      step     <= '0;
      opcode_q <= '0;
    end else if (input_clock_enable) begin
      case (state)
        ST_FETCH: begin
          if (bus.input_mem_ack) begin
            opcode_q <= bus.input_opcode;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          step  <= '0;
          state <= info.is_halt ? ST_HALTED : ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (last_step) begin
            step  <= '0;
            state <= ST_INCREMENT;
          end else begin
            step <= step + 2'd1;
          end
        end
        ST_INCREMENT: state <= ST_FETCH;
        ST_HALTED:    state <= ST_HALTED;
        default:      state <= ST_FETCH;
      endcase
    end
  end

  // One-hot phase vector decoded from state; HALTED leaves it all zero.
  always_comb begin
    phase               = '0;
    phase[PH_FETCH]     = (state == ST_FETCH);
    phase[PH_DECODE]    = (state == ST_DECODE);
    phase[PH_EXECUTE]   = (state == ST_EXECUTE);
    phase[PH_INCREMENT] = (state == ST_INCREMENT);
  end

  // ir_load tracks DECODE, which is exactly the cycle after the fetch edge.
  assign bus.output_fetch        = phase[PH_FETCH];
  assign bus.output_decode       = phase[PH_DECODE];
  assign bus.output_execute      = phase[PH_EXECUTE];
  assign bus.output_increment    = phase[PH_INCREMENT];
  assign bus.output_mem_req      = phase[PH_FETCH];
  assign bus.output_ir_load      = phase[PH_DECODE];
  assign bus.output_exec_step    = phase[PH_EXECUTE] ? step : 2'd0;
  assign bus.output_pc_load      = phase[PH_EXECUTE] && (step == 2'd0) && info.is_jump;
  assign bus.output_pc_increment = phase[PH_INCREMENT] && !info.is_jump;
  assign bus.output_halted       = (state == ST_HALTED);

endmodule

// File: tb/tb_cycle_controller.sv
// Directed bench for cycle_controller with hand-computed output vectors.
// Vector layout: {fetch, decode, execute, increment, mem_req, ir_load,
//                 exec_step[1:0], pc_increment, pc_load, halted}
module tb_cycle_controller;

  localparam logic [10:0] V_FETCH  = 11'b1000_1000_000;
  localparam logic [10:0] V_DECODE = 11'b0100_0100_000;
  localparam logic [10:0] V_INC    = 11'b0001_0000_100;
  localparam logic [10:0] V_INC_NP = 11'b0001_0000_000;
  localparam logic [10:0] V_HALT   = 11'b0000_0000_001;

  logic clock;
  logic input_clear_n;
  logic input_clock_enable;
  int   vectors;
  int   fails;

  cycle_controller_if #(.OPCODE_WIDTH(4)) bus ();

  cycle_controller #(.OPCODE_WIDTH(4)) dut (
    .clock              (clock),
    .input_clear_n      (input_clear_n),
    .input_clock_enable (input_clock_enable),
    .bus                (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [10:0] ex(input logic [1:0] s, input logic pl);
    return 11'b0010_0000_000 | {6'b0, s, 1'b0, pl, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {bus.output_fetch, bus.output_decode, bus.output_execute,
           bus.output_increment, bus.output_mem_req, bus.output_ir_load,
           bus.output_exec_step, bus.output_pc_increment,
           bus.output_pc_load, bus.output_halted};
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    fails   = 0;
    input_clear_n      = 1'b1;
    input_clock_enable = 1'b1;
    bus.input_mem_ack  = 1'b0;
    bus.input_opcode   = 4'h0;

    // Asynchronous reset asserted mid-cycle, before any clock edge.
    #2 input_clear_n = 1'b0;
    #1 chk("reset_async", V_FETCH);
    tick();
    chk("reset_hold", V_FETCH);
    input_clear_n = 1'b0;
    #1 input_clear_n = 1'b1;

    // NOP with ack tied high: 4-cycle loop.
    bus.input_opcode  = 4'h0;
    bus.input_mem_ack = 1'b1;
    tick(); chk("nop_decode", V_DECODE);
    tick(); chk("nop_exec0", ex(2'd0, 1'b0));
    tick(); chk("nop_inc", V_INC);
    tick(); chk("nop_fetch", V_FETCH);
    tick(); chk("nop_loop_decode", V_DECODE);
    tick(); chk("nop_loop_exec0", ex(2'd0, 1'b0));
    tick(); chk("nop_loop_inc", V_INC);
    bus.input_mem_ack = 1'b0;
    tick(); chk("lda_fetch1", V_FETCH);

    // LDA with ack delayed two cycles; opcode bus changes after the latch.
    bus.input_opcode = 4'h1;
    tick(); chk("lda_fetch2", V_FETCH);
    tick(); chk("lda_fetch3", V_FETCH);
    bus.input_mem_ack = 1'b1;
    tick(); chk("lda_decode", V_DECODE);
    bus.input_opcode = 4'hF;
    tick(); chk("lda_exec0", ex(2'd0, 1'b0));
    tick(); chk("lda_exec1", ex(2'd1, 1'b0));
    tick(); chk("lda_exec2", ex(2'd2, 1'b0));
    bus.input_mem_ack = 1'b0;
    bus.input_opcode  = 4'h6;
    tick(); chk("lda_inc", V_INC);
    tick(); chk("lda_back_fetch", V_FETCH);

    // Ack seen only while enable is low must be ignored.
    input_clock_enable = 1'b0;
    bus.input_mem_ack  = 1'b1;
    tick(); chk("ce0_ack_ignored", V_FETCH);
    input_clock_enable = 1'b1;

    // JMP: pc_load at step 0, no pc_increment.
    tick(); chk("jmp_decode", V_DECODE);
    bus.input_mem_ack = 1'b0;
    tick(); chk("jmp_exec0", ex(2'd0, 1'b1));
    tick(); chk("jmp_inc", V_INC_NP);
    tick(); chk("jmp_fetch", V_FETCH);

    // ADD with enable dropped for three cycles at step 1.
    bus.input_opcode  = 4'h2;
    bus.input_mem_ack = 1'b1;
    tick(); chk("add_decode", V_DECODE);
    bus.input_mem_ack = 1'b0;
    tick(); chk("add_exec0", ex(2'd0, 1'b0));
    tick(); chk("add_exec1", ex(2'd1, 1'b0));
    input_clock_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("add_frozen", ex(2'd1, 1'b0));
    end
    input_clock_enable = 1'b1;
    tick(); chk("add_exec2", ex(2'd2, 1'b0));
    tick(); chk("add_inc", V_INC);
    tick(); chk("add_fetch", V_FETCH);

    // STA: two execute steps.
    bus.input_opcode  = 4'h4;
    bus.input_mem_ack = 1'b1;
    tick(); chk("sta_decode", V_DECODE);
    bus.input_mem_ack = 1'b0;
    tick(); chk("sta_exec0", ex(2'd0, 1'b0));
    tick(); chk("sta_exec1", ex(2'd1, 1'b0));
    tick(); chk("sta_inc", V_INC);
    tick(); chk("sta_fetch", V_FETCH);

    // 0xE: top of the single-step range; ack during execute is ignored.
    bus.input_opcode  = 4'hE;
    bus.input_mem_ack = 1'b1;
    tick(); chk("opE_decode", V_DECODE);
    tick(); chk("opE_exec0", ex(2'd0, 1'b0));
    tick(); chk("opE_inc", V_INC);
    bus.input_mem_ack = 1'b0;
    tick(); chk("opE_fetch", V_FETCH);

    // HLT: held in HALTED for 10 cycles with ack toggling.
    bus.input_opcode  = 4'hF;
    bus.input_mem_ack = 1'b1;
    tick(); chk("hlt_decode", V_DECODE);
    tick(); chk("hlt_halted", V_HALT);
    for (int i = 0; i < 10; i++) begin
      bus.input_mem_ack = (i % 2 == 0);
      tick(); chk("hlt_hold", V_HALT);
    end
    input_clear_n = 1'b0;
    #1 chk("hlt_reset_async", V_FETCH);
    #2 input_clear_n = 1'b1;
    bus.input_mem_ack = 1'b0;
    bus.input_opcode  = 4'h1;
    tick(); chk("post_hlt_fetch", V_FETCH);

    // Reset mid-EXECUTE abandons the instruction with no pc pulse.
    bus.input_mem_ack = 1'b1;
    tick(); chk("abort_decode", V_DECODE);
    bus.input_mem_ack = 1'b0;
    tick(); chk("abort_exec0", ex(2'd0, 1'b0));
    tick(); chk("abort_exec1", ex(2'd1, 1'b0));
    input_clear_n = 1'b0;
    #1 chk("abort_reset", V_FETCH);
    #2 input_clear_n = 1'b1;
    tick(); chk("abort_after", V_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
